stopwatch_display: RTL and testbench

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

---
 rtl/stopwatch_display_pkg.sv | 54 +++++
 rtl/stopwatch_display_if.sv | 12 +
 rtl/stopwatch_display_bin2bcd.sv | 76 +++++++
 rtl/stopwatch_display.sv | 138 +++++++++++++
 tb/tb_stopwatch_display.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch display slice: field/digit counts,
// internal digit codes, active-low segment patterns and the converter
// state type.
package stopwatch_pkg;

    localparam int NUM_FIELDS = 5;
    localparam int NUM_DIGITS = 10;

    // Field index value meaning "frame complete, waiting for frame_start".
    localparam logic [2:0] FIELD_DONE = 3'(NUM_FIELDS);
    localparam logic [2:0] LAST_FIELD = 3'(NUM_FIELDS - 1);

    // Digit codes 0..9 are plain BCD; two extra codes for non-numeric glyphs.
    localparam logic [3:0] DIG_DASH  = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    // Segment patterns {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_CONV  = 2'd1,
        CS_WRITE = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:     return SEG_0;
            4'd1:     return SEG_1;
            4'd2:     return SEG_2;
            4'd3:     return SEG_3;
            4'd4:     return SEG_4;
            4'd5:     return SEG_5;
            4'd6:     return SEG_6;
            4'd7:     return SEG_7;
            4'd8:     return SEG_8;
            4'd9:     return SEG_9;
            DIG_DASH: return SEG_DASH;
            default:  return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Field stream from the time transmitter.
//   din         : binary field value
//   din_valid   : one-cycle strobe qualifying din
//   frame_start : with din_valid, marks din as field 0
interface stopwatch_display_if;
    logic [6:0] din;
    logic       din_valid;
    logic       frame_start;

    modport master (output din, output din_valid, output frame_start);
    modport slave  (input  din, input  din_valid, input  frame_start);
endinterface

// File: rtl/stopwatch_display_bin2bcd.sv
// Iterative binary-to-two-digit converter (subtract 10 per cycle).
//   start_i/value_i : load a value (accepted only in IDLE)
//   busy_o          : high while not IDLE
//   done_o          : high for the WRITE cycle; ones_o/tens_o valid then
// Values above 99 produce DASH in both digits after a single CONV cycle.
//
// state    | meaning
// ---------+-----------------------------------------------
// CS_IDLE  | waiting for start_i
// CS_CONV  | remainder >= 10: subtract 10, count a ten
// CS_WRITE | result valid for one cycle, then back to IDLE
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [6:0] value_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] ones_o,
    output logic [3:0] tens_o
);

    conv_state_t state_q, state_d;
    logic [6:0]  rem_q, rem_d;
    logic [3:0]  tens_q, tens_d;
    logic        dash_q, dash_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tens_d  = tens_q;
        dash_d  = dash_q;
        case (state_q)
            CS_IDLE: begin
                if (start_i) begin
                    state_d = CS_CONV;
                    rem_d   = value_i;
                    tens_d  = 4'd0;
                    dash_d  = (value_i > 7'd99);
                end
            end
            CS_CONV: begin
                if (dash_q || (rem_q < 7'd10)) begin
                    state_d = CS_WRITE;
                end else begin
                    rem_d  = rem_q - 7'd10;
                    tens_d = tens_q + 4'd1;
                end
            end
            CS_WRITE: state_d = CS_IDLE;
            default:  state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CS_IDLE;
            rem_q   <= '0;
            tens_q  <= '0;
            dash_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
            dash_q  <= dash_d;
        end
    end

    assign busy_o = (state_q != CS_IDLE);
    assign done_o = (state_q == CS_WRITE);
    assign ones_o = dash_q ? DIG_DASH : rem_q[3:0];
    assign tens_o = dash_q ? DIG_DASH : tens_q;

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display: converts a 5-field time frame to BCD into a shadow
// buffer, commits a complete frame atomically, and multiplexes 10 digits.
//   clk, reset   : clock, async active-low reset
//   bus          : field stream (din, din_valid, frame_start)
//   seg, dp      : active-low segments {g..a} and decimal point
//   dig_en       : one-hot active-low digit select
//   busy         : converter not IDLE
//   overrun      : sticky, a strobe arrived while busy
//   frame_err    : one-cycle pulse on protocol or range error
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV      = 7374,
    parameter bit BLANK_DY_TENS = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    stopwatch_display_if.slave bus,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [9:0]         dig_en,
    output logic               busy,
    output logic               overrun,
    output logic               frame_err
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic       conv_busy, conv_done;
    logic [3:0] conv_ones, conv_tens;
    logic       accept, drop_busy, drop_done;

    logic [2:0] field_q, field_d;
    logic [2:0] cur_field_q;
    logic       commit_q;
    logic       overrun_q, frame_err_q;
    logic [3:0] shadow_q [NUM_DIGITS];
    logic [3:0] disp_q   [NUM_DIGITS];
    logic [3:0] wr_idx;

    logic [DIV_W-1:0] div_q;
    logic [3:0]       digit_q;
    logic             scan_tc;
    logic [3:0]       cur_code;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [9:0]       dig_en_q;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept),
        .value_i (bus.din),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .ones_o  (conv_ones),
        .tens_o  (conv_tens)
    );

    // A strobe while busy is an overrun; a non-start strobe after field 4
    // is a protocol error. Neither advances the field index.
    assign drop_busy = bus.din_valid && conv_busy;
    assign drop_done = bus.din_valid && !conv_busy && !bus.frame_start
                       && (field_q == FIELD_DONE);
    assign accept    = bus.din_valid && !conv_busy && !drop_done;
    assign field_d   = bus.frame_start ? 3'd1 : field_q + 3'd1;
    assign wr_idx    = {cur_field_q, 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field_q     <= FIELD_DONE;
            cur_field_q <= '0;
            commit_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            frame_err_q <= drop_done || (accept && (bus.din > 7'd99));
            overrun_q   <= overrun_q || drop_busy;
            if (accept) begin
                field_q     <= field_d;
                cur_field_q <= bus.frame_start ? 3'd0 : field_q;
            end
            // A mid-frame restart simply overwrites the shadow; only a
            // finished field 4 ever reaches the display buffer.
            if (conv_done) begin
                shadow_q[wr_idx]        <= conv_ones;
                shadow_q[wr_idx + 4'd1] <= conv_tens;
            end
            commit_q <= conv_done && (cur_field_q == LAST_FIELD);
            if (commit_q) begin
                for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= shadow_q[i];
            end
        end
    end

    assign scan_tc = (div_q == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            digit_q <= '0;
        end else begin
            div_q <= scan_tc ? '0 : div_q + 1'b1;
            if (scan_tc) digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_comb begin
        cur_code = disp_q[digit_q];
        if (BLANK_DY_TENS && (digit_q == 4'd9) && (cur_code == 4'd0)) cur_code = DIG_BLANK;
    end

    // Outputs are built from registered digit index and buffer together, so
    // a commit landing on a scan advance shows new data on the new digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            dig_en_q <= '1;
        end else begin
            seg_q    <= seg_decode(cur_code);
            dp_q     <= !((digit_q != 4'd0) && !digit_q[0]);
            dig_en_q <= ~(10'd1 << digit_q);
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign dig_en    = dig_en_q;
    assign busy      = conv_busy;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [9:0] dig_en;
    logic       busy, overrun, frame_err;

    int checks = 0;
    int failures = 0;

    logic [6:0] cap_seg [10];
    logic       cap_dp  [10];
    int         exp_d   [10];

    stopwatch_display_if sw_if ();

    stopwatch_display #(.SCAN_DIV(4), .BLANK_DY_TENS(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (sw_if),
        .seg       (seg),
        .dp        (dp),
        .dig_en    (dig_en),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] tb_seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic send(input logic [6:0] v, input logic fs);
        @(negedge clk);
        sw_if.din = v; sw_if.din_valid = 1'b1; sw_if.frame_start = fs;
        @(negedge clk);
        sw_if.din_valid = 1'b0; sw_if.frame_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL wait_idle busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic send_frame(input int v0, input int v1, input int v2, input int v3, input int v4);
        send(7'(v0), 1'b1); wait_idle();
        send(7'(v1), 1'b0); wait_idle();
        send(7'(v2), 1'b0); wait_idle();
        send(7'(v3), 1'b0); wait_idle();
        send(7'(v4), 1'b0); wait_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic capture();
        for (int i = 0; i < 10; i++) begin cap_seg[i] = 7'hxx; cap_dp[i] = 1'bx; end
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            for (int i = 0; i < 10; i++)
                if (dig_en == ~(10'd1 << i)) begin cap_seg[i] = seg; cap_dp[i] = dp; end
        end
    endtask

    task automatic test_reset();
        logic [9:0] exp_en;
        sw_if.din = '0; sw_if.din_valid = 1'b0; sw_if.frame_start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL rst_seg got=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL rst_dp got=%b exp=1", dp); end
        checks++; if (dig_en !== 10'h3FF) begin failures++; $display("FAIL rst_dig_en got=%h exp=3ff", dig_en); end
        checks++; if ({busy, overrun, frame_err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, overrun, frame_err}); end
        reset = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            exp_en = ~(10'd1 << (((k - 1) / 4) % 10));
            checks++; if (dig_en !== exp_en) begin failures++; $display("FAIL scan_k%0d got=%h exp=%h", k, dig_en, exp_en); end
            if (k == 1) begin
                checks++; if (seg !== 7'h40) begin failures++; $display("FAIL scan_first_seg got=%h exp=40", seg); end
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (dig_en !== 10'h3FF) begin failures++; $display("FAIL midscan_rst_dig_en got=%h exp=3ff", dig_en); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL midscan_rst_seg got=%h exp=7f", seg); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_frame();
        send_frame(47, 59, 59, 23, 99);
        capture();
        exp_d = '{7, 4, 9, 5, 9, 5, 3, 2, 9, 9};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL frame_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
            checks++; if (cap_dp[i] !== ((i == 2 || i == 4 || i == 6 || i == 8) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL frame_dp_d%0d got=%b", i, cap_dp[i]); end
        end
    endtask

    task automatic test_overrun();
        int cnt = 0;
        send(7'd99, 1'b1);
        for (int k = 0; k < 30; k++) begin
            if (busy) cnt++;
            if (k == 2) begin
                checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun); end
                sw_if.din = 7'd11; sw_if.din_valid = 1'b1; sw_if.frame_start = 1'b0;
            end
            if (k == 3) begin
                sw_if.din_valid = 1'b0;
                checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
            end
            @(negedge clk);
        end
        checks++; if (cnt !== 11) begin failures++; $display("FAIL busy_99_cycles got=%0d exp=11", cnt); end
        send(7'd59, 1'b0); wait_idle();
        send(7'd59, 1'b0); wait_idle();
        send(7'd23, 1'b0); wait_idle();
        send(7'd99, 1'b0); wait_idle();
        repeat (3) @(negedge clk);
        capture();
        exp_d = '{9, 9, 9, 5, 9, 5, 3, 2, 9, 9};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL ovr_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
        end
    endtask

    task automatic test_range();
        int cnt = 0;
        send(7'd1, 1'b1); wait_idle();
        send(7'd2, 1'b0); wait_idle();
        send(7'd120, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (busy) cnt++;
            if (k == 0) begin
                checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL range_err_pulse got=%b exp=1", frame_err); end
            end
            if (k == 1) begin
                checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL range_err_clear got=%b exp=0", frame_err); end
            end
            @(negedge clk);
        end
        checks++; if (cnt !== 2) begin failures++; $display("FAIL range_busy_cycles got=%0d exp=2", cnt); end
        send(7'd3, 1'b0); wait_idle();
        send(7'd4, 1'b0); wait_idle();
        repeat (3) @(negedge clk);
        capture();
        exp_d = '{1, 0, 2, 0, 10, 10, 3, 0, 4, 11};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL range_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
        end
    endtask

    task automatic test_extra_strobe();
        send(7'd5, 1'b0);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL extra_err_pulse got=%b exp=1", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL extra_busy got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL extra_err_clear got=%b exp=0", frame_err); end
        capture();
        exp_d = '{1, 0, 2, 0, 10, 10, 3, 0, 4, 11};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL extra_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
        end
    endtask

    task automatic test_partial_frame();
        send(7'd11, 1'b1); wait_idle();
        send(7'd22, 1'b0); wait_idle();
        send(7'd33, 1'b0); wait_idle();
        capture();
        exp_d = '{1, 0, 2, 0, 10, 10, 3, 0, 4, 11};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL partial_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
        end
        send_frame(0, 0, 0, 0, 0);
        capture();
        exp_d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 11};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL zeros_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
        end
    endtask

    task automatic test_reset_mid_conv();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        send(7'd10, 1'b1); wait_idle();
        send(7'd20, 1'b0); wait_idle();
        send(7'd30, 1'b0); wait_idle();
        send(7'd40, 1'b0); wait_idle();
        send(7'd99, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midconv_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midconv_ovr got=%b exp=0", overrun); end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midconv_busy_after got=%b exp=0", busy); end
        capture();
        exp_d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 11};
        for (int i = 0; i < 10; i++) begin
            checks++; if (cap_seg[i] !== tb_seg(exp_d[i])) begin failures++; $display("FAIL midconv_seg_d%0d got=%h exp=%h", i, cap_seg[i], tb_seg(exp_d[i])); end
        end
        send(7'd5, 1'b0);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL post_rst_index got=%b exp=1", frame_err); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_range();
        test_extra_strobe();
        test_partial_frame();
        test_reset_mid_conv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
